// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed 8-digit common-anode hex panel driver with frame-aligned input shadowing.
// Optional operand-view blinking is compiled in with the HEX_BLINK_EN macro.
module hex_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] display,
    input  logic [7:0]  modo,
    input  logic        sinal,
    output logic [7:0]  anodo,
    output logic [6:0]  segmentos,
    output logic        ponto,
    output logic        frame
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_param
        $error("hex_scan_driver: SCAN_DIV must be >= 2 and BLINK_FRAMES >= 1");
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      sh_display_q, sh_display_d;
    logic [7:0]       sh_modo_q, sh_modo_d;
    logic             sh_sinal_q, sh_sinal_d;
    logic             primed_q, primed_d;
    logic [7:0]       anodo_q, anodo_d;
    logic [6:0]       seg_q, seg_d;
    logic             ponto_q, ponto_d;
    logic             frame_q, frame_d;
    logic             tc, boundary, load;
    logic [3:0]       nib;

    // The priming cycle holds the divider so digit 0 of the first frame gets its full SCAN_DIV cycles.
    always_comb begin
        div_d        = div_q;
        idx_d        = idx_q;
        sh_display_d = sh_display_q;
        sh_modo_d    = sh_modo_q;
        sh_sinal_d   = sh_sinal_q;
        primed_d     = 1'b1;
        tc           = primed_q && (div_q == DIV_LAST);
        boundary     = tc && (idx_q == 3'd7);
        load         = !primed_q || boundary;
        if (primed_q) begin
            div_d = tc ? '0 : div_q + DIV_W'(1);
            if (tc) idx_d = idx_q + 3'd1;
        end
        if (load) begin
            sh_display_d = display;
            sh_modo_d    = modo;
            sh_sinal_d   = sinal;
        end
        frame_d = load;
    end

`ifdef HEX_BLINK_EN
    localparam int               FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            phase_q, phase_d;

    // Only real frame boundaries advance the count; the priming load starts frame 0 without counting.
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (boundary) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end
`endif

    always_comb begin
        anodo_d = 8'hFF;
        seg_d   = 7'h7F;
        ponto_d = 1'b1;
        nib     = sh_display_q[{idx_q, 2'b00} +: 4];
        if (primed_q) begin
            anodo_d = ~(8'd1 << idx_q);
            if (sh_modo_q[idx_q]) seg_d = hex7(nib);
            if (idx_q == 3'd4 && sh_sinal_q) ponto_d = 1'b0;
`ifdef HEX_BLINK_EN
            if (!sh_sinal_q && phase_q) begin
                seg_d   = 7'h7F;
                ponto_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q        <= '0;
            idx_q        <= '0;
            sh_display_q <= '0;
            sh_modo_q    <= '0;
            sh_sinal_q   <= 1'b0;
            primed_q     <= 1'b0;
            anodo_q      <= 8'hFF;
            seg_q        <= 7'h7F;
            ponto_q      <= 1'b1;
            frame_q      <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            sh_display_q <= sh_display_d;
            sh_modo_q    <= sh_modo_d;
            sh_sinal_q   <= sh_sinal_d;
            primed_q     <= primed_d;
            anodo_q      <= anodo_d;
            seg_q        <= seg_d;
            ponto_q      <= ponto_d;
            frame_q      <= frame_d;
        end
    end

    assign anodo     = anodo_q;
    assign segmentos = seg_q;
    assign ponto     = ponto_q;
    assign frame     = frame_q;

endmodule
